// File: rtl/uart_poll_master.sv
// Bus initiator that polls a memory-mapped UART: drains received bytes into an
// RX FIFO and feeds TX FIFO bytes to the transmitter whenever it reports TxRDY.
module uart_poll_master #(
    parameter int DEPTH    = 4,
    parameter int POLL_GAP = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tx_write_i,
    input  logic [7:0]  tx_byte_i,
    output logic        tx_full_o,
    input  logic        rx_read_i,
    output logic [7:0]  rx_byte_o,
    output logic        rx_empty_o,
    output logic [7:0]  parity_err_count_o,
    output logic        ce_sr_o,
    output logic        ce_uart_o,
    output logic        rd_o,
    output logic        wr_o,
    output logic [31:0] write_data_o,
    input  logic [31:0] read_data_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    typedef enum logic [1:0] {S_GAP, S_POLL, S_RXRD, S_TXWR} state_e;

    state_e        state_q;
    logic [GW-1:0] gap_cnt_q;
    logic          ce_sr_q, ce_uart_q, rd_q, wr_q;
    logic [7:0]    wdata_q;
    logic          perr_q;
    logic [7:0]    perr_cnt_q;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          tx_full_q, tx_push, tx_pop;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rx_empty_q, rx_push, rx_pop;
    logic [7:0]    rx_byte_q;

    logic          unused_rdata;
    assign unused_rdata = ^read_data_i[31:8];

    // A TX pop in the same edge frees a slot, so a push to a full FIFO still lands.
    always_comb begin
        tx_pop   = (state_q == S_TXWR);
        tx_push  = tx_write_i && (!tx_full_q || tx_pop);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_push  = (state_q == S_RXRD);
        rx_pop   = rx_read_i && !rx_empty_q;
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_byte_i;
        if (rx_push) rx_mem[rx_wr_ptr_q] <= read_data_i[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            rx_empty_q  <= 1'b1;
            rx_byte_q   <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + AW'(1);
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + AW'(1);
            tx_cnt_q   <= tx_cnt_d;
            tx_full_q  <= (tx_cnt_d == FULL_CNT);
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + AW'(1);
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + AW'(1);
            rx_cnt_q   <= rx_cnt_d;
            rx_empty_q <= (rx_cnt_d == '0);
            rx_byte_q  <= rx_mem[rx_rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_GAP;
            gap_cnt_q  <= '0;
            ce_sr_q    <= 1'b0;
            ce_uart_q  <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            perr_q     <= 1'b0;
            perr_cnt_q <= '0;
        end else begin
            case (state_q)
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= '0;
                        state_q   <= S_POLL;
                        ce_sr_q   <= 1'b1;
                        rd_q      <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                S_POLL: begin
                    ce_sr_q <= 1'b0;
                    rd_q    <= 1'b0;
                    perr_q  <= read_data_i[2];
                    // Receive wins over transmit so the peripheral's RX holding register never overruns.
                    if (read_data_i[1] && (rx_cnt_q != FULL_CNT)) begin
                        state_q   <= S_RXRD;
                        ce_uart_q <= 1'b1;
                        rd_q      <= 1'b1;
                    end else if (read_data_i[0] && (tx_cnt_q != '0)) begin
                        state_q   <= S_TXWR;
                        ce_uart_q <= 1'b1;
                        wr_q      <= 1'b1;
                        wdata_q   <= tx_mem[tx_rd_ptr_q];
                    end else begin
                        state_q <= S_GAP;
                    end
                end
                S_RXRD: begin
                    state_q   <= S_GAP;
                    ce_uart_q <= 1'b0;
                    rd_q      <= 1'b0;
                    if (perr_q && (perr_cnt_q != 8'hFF)) perr_cnt_q <= perr_cnt_q + 8'd1;
                end
                S_TXWR: begin
                    state_q   <= S_GAP;
                    ce_uart_q <= 1'b0;
                    wr_q      <= 1'b0;
                    wdata_q   <= '0;
                end
                default: begin
                    state_q   <= S_GAP;
                    ce_sr_q   <= 1'b0;
                    ce_uart_q <= 1'b0;
                    rd_q      <= 1'b0;
                    wr_q      <= 1'b0;
                end
            endcase
        end
    end

    assign tx_full_o          = tx_full_q;
    assign rx_byte_o          = rx_byte_q;
    assign rx_empty_o         = rx_empty_q;
    assign parity_err_count_o = perr_cnt_q;
    assign ce_sr_o            = ce_sr_q;
    assign ce_uart_o          = ce_uart_q;
    assign rd_o               = rd_q;
    assign wr_o               = wr_q;
    assign write_data_o       = {24'b0, wdata_q};

endmodule
